// File: rtl/dot_matrix_pkg.sv
// Shared constants and column word type for the 16x16 dot-matrix driver.
// DOT_MATRIX_ACTIVE_LOW_ROWS_EN selects inverted (active-low) row drive.
package dot_matrix_pkg;

   localparam int NUM_ROWS  = 16;
   localparam int NUM_COLS  = 16;
   localparam int NUM_BANKS = 2;
   localparam int COL_ID_W  = 5;
   localparam int SEL_W     = 4;

   typedef logic [NUM_ROWS-1:0] col_word_t;

`ifdef DOT_MATRIX_ACTIVE_LOW_ROWS_EN
   localparam col_word_t ROW_IDLE = '1;
`else
   localparam col_word_t ROW_IDLE = '0;
`endif

   // Buffer stores 1 = LED on; this maps it to the pin polarity of the row drivers.
   function automatic col_word_t drive_rows(input col_word_t word);
`ifdef DOT_MATRIX_ACTIVE_LOW_ROWS_EN
      return ~word;
`else
      return word;
`endif
   endfunction

endpackage

// File: rtl/dot_matrix_driver_load_edge_sync.sv
// Two-flop synchronizer for an asynchronous strobe plus a one-cycle rising-edge pulse.
module load_edge_sync (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic async_in,
   output logic rise_pulse
);

   logic sync1_q, sync2_q, prev_q;
   logic sync1_d, sync2_d, prev_d;

   always_comb begin
      sync1_d = async_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   // High for the single cycle ending on the 3rd edge after the strobe rises.
   assign rise_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/dot_matrix_driver.sv
// Frame buffer (two 16-column banks) and column scan controller for a 16x16 LED matrix.
// Build option: DOT_MATRIX_ACTIVE_LOW_ROWS_EN drives out_column inverted (idle 16'hFFFF).
module dot_matrix_driver
   import dot_matrix_pkg::*;
#(
   parameter int SCAN_DIV     = 1024,
   parameter int BLANK_CYCLES = 4
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [COL_ID_W-1:0] column_id,
   input  col_word_t           in_column,
   input  logic                LOAD,
   input  logic                IN_CLR,
   output logic [SEL_W-1:0]    column_seg,
   output col_word_t           out_column,
   output logic                COLUMN_CLK,
   output logic                OUT_CLR
);

   localparam int FRAME_DEPTH = NUM_BANKS * NUM_COLS;
   localparam int CNT_W       = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] SLOT_LOAD = CNT_W'(SCAN_DIV - 1);

   logic wr_pulse;

   col_word_t        frame_q [FRAME_DEPTH];
   col_word_t        frame_d [FRAME_DEPTH];
   logic             bank_q, bank_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [SEL_W-1:0] column_seg_q, column_seg_d;
   col_word_t        out_column_q, out_column_d;
   logic             column_clk_q, column_clk_d;
   logic             out_clr_q, out_clr_d;

   load_edge_sync u_load_sync (
      .clk_sys    (CLK),
      .rst_b      (RESET),
      .async_in   (LOAD),
      .rise_pulse (wr_pulse)
   );

   // A clear suppresses a coincident write entirely, including its bank select.
   always_comb begin
      frame_d = frame_q;
      bank_d  = bank_q;
      if (IN_CLR) begin
         frame_d = '{default: '0};
      end else if (wr_pulse) begin
         frame_d[column_id] = in_column;
         bank_d             = column_id[COL_ID_W-1];
      end
   end

   // rem counts down from SCAN_DIV-1; elapsed slot time is SCAN_DIV-1-rem.
   always_comb begin
      rem_d        = rem_q - CNT_W'(1);
      column_seg_d = column_seg_q;
      out_column_d = out_column_q;
      if (rem_q == '0) begin
         rem_d        = SLOT_LOAD;
         column_seg_d = column_seg_q + SEL_W'(1);
         out_column_d = drive_rows(frame_q[{bank_q, column_seg_d}]);
      end
      out_clr_d    = (int'(rem_d) >= SCAN_DIV - BLANK_CYCLES);
      column_clk_d = (int'(rem_d) <  SCAN_DIV - BLANK_CYCLES) &&
                     (int'(rem_d) >= SCAN_DIV / 2);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         frame_q      <= '{default: '0};
         bank_q       <= 1'b0;
         rem_q        <= SLOT_LOAD;
         column_seg_q <= '0;
         out_column_q <= ROW_IDLE;
         column_clk_q <= 1'b0;
         out_clr_q    <= 1'b1;
      end else begin
         frame_q      <= frame_d;
         bank_q       <= bank_d;
         rem_q        <= rem_d;
         column_seg_q <= column_seg_d;
         out_column_q <= out_column_d;
         column_clk_q <= column_clk_d;
         out_clr_q    <= out_clr_d;
      end
   end

   assign column_seg = column_seg_q;
   assign out_column = out_column_q;
   assign COLUMN_CLK = column_clk_q;
   assign OUT_CLR    = out_clr_q;

endmodule

// File: tb/tb_dot_matrix_driver.sv
// Directed bench for dot_matrix_driver with SCAN_DIV=8, BLANK_CYCLES=2.
module tb_dot_matrix_driver;
   import dot_matrix_pkg::*;

   localparam int SD = 8;
   localparam int BC = 2;
   localparam int FRAME = 16 * SD;

   logic            CLK = 1'b0;
   logic            RESET = 1'b0;
   logic [4:0]      column_id = '0;
   col_word_t       in_column = '0;
   logic            LOAD = 1'b0;
   logic            IN_CLR = 1'b0;
   logic [3:0]      column_seg;
   col_word_t       out_column;
   logic            COLUMN_CLK;
   logic            OUT_CLR;

   int        n_checks = 0;
   int        n_err = 0;
   int        cyc;
   col_word_t exp_frame [32];
   logic      exp_bank;

   dot_matrix_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .column_id  (column_id),
      .in_column  (in_column),
      .LOAD       (LOAD),
      .IN_CLR     (IN_CLR),
      .column_seg (column_seg),
      .out_column (out_column),
      .COLUMN_CLK (COLUMN_CLK),
      .OUT_CLR    (OUT_CLR)
   );

   always #5 CLK = ~CLK;

   // Edges since reset release: slot time = cyc % SD, column = (cyc / SD) % 16.
   always @(posedge CLK or negedge RESET) begin
      if (!RESET) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic col_word_t rows(input col_word_t w);
`ifdef DOT_MATRIX_ACTIVE_LOW_ROWS_EN
      return ~w;
`else
      return w;
`endif
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_seg"}, 32'(column_seg), 32'd0);
      check({tag, "_out"}, 32'(out_column), 32'(rows(16'h0000)));
      check({tag, "_clr"}, 32'(OUT_CLR), 32'd1);
      check({tag, "_cclk"}, 32'(COLUMN_CLK), 32'd0);
   endtask

   task automatic check_timing(input string tag);
      int c;
      int s;
      c = cyc % SD;
      s = (cyc / SD) % 16;
      check({tag, "_seg"}, 32'(column_seg), 32'(s));
      check({tag, "_clr"}, 32'(OUT_CLR), (c < BC) ? 32'd1 : 32'd0);
      check({tag, "_cclk"}, 32'(COLUMN_CLK), (c >= BC && c < SD / 2) ? 32'd1 : 32'd0);
   endtask

   task automatic write_col(input logic [4:0] id, input col_word_t data);
      @(negedge CLK);
      column_id = id;
      in_column = data;
      LOAD = 1'b1;
      @(negedge CLK);
      LOAD = 1'b0;
      repeat (5) @(negedge CLK);
      exp_frame[id] = data;
      exp_bank = id[4];
   endtask

   task automatic wait_phase(input int phase, output logic found);
      found = 1'b0;
      for (int i = 0; i < 3 * FRAME && !found; i++) begin
         if (cyc % FRAME == phase) found = 1'b1;
         else @(negedge CLK);
      end
   endtask

   // Checks one full frame at mid-slot of every column, starting from a frame that began after the last write.
   task automatic check_frame(input string tag);
      logic found;
      repeat (SD) @(negedge CLK);
      wait_phase(SD / 2, found);
      check({tag, "_sync"}, 32'(found), 32'd1);
      if (found) begin
         for (int j = 0; j < 16; j++) begin
            check({tag, "_seg"}, 32'(column_seg), 32'(j));
            check({tag, "_out"}, 32'(out_column), 32'(rows(exp_frame[int'(exp_bank) * 16 + j])));
            repeat (SD) @(negedge CLK);
         end
      end
   endtask

   initial begin
      logic found;
      exp_frame = '{default: '0};
      exp_bank  = 1'b0;

      repeat (3) @(negedge CLK);
      check_reset_vals("reset");
      RESET = 1'b1;
      for (int k = 0; k < 17 * SD; k++) begin
         check_timing("scan");
         @(negedge CLK);
      end

      write_col(5'd3, 16'hA5C3);
      check_frame("wr3");
      write_col(5'd19, 16'h00FF);
      check_frame("bank1");
      write_col(5'd3, 16'hA5C3);
      check_frame("bank0");

      // IN_CLR coincides with the write edge (3rd edge after LOAD rises).
      @(negedge CLK);
      column_id = 5'd0;
      in_column = 16'hFFFF;
      LOAD = 1'b1;
      @(negedge CLK);
      LOAD = 1'b0;
      @(negedge CLK);
      IN_CLR = 1'b1;
      @(negedge CLK);
      IN_CLR = 1'b0;
      repeat (4) @(negedge CLK);
      exp_frame = '{default: '0};
      check_frame("clr");

      // Data changes on both sides of the write edge pin down its exact position.
      @(negedge CLK);
      column_id = 5'd10;
      in_column = 16'h1111;
      LOAD = 1'b1;
      @(negedge CLK);
      LOAD = 1'b0;
      @(negedge CLK);
      in_column = 16'h2222;
      @(negedge CLK);
      in_column = 16'h3333;
      repeat (5) @(negedge CLK);
      exp_frame[10] = 16'h2222;
      exp_bank = 1'b0;
      check_frame("lat");

      @(negedge CLK);
      column_id = 5'd7;
      in_column = 16'h1234;
      LOAD = 1'b1;
      repeat (5) @(negedge CLK);
      in_column = 16'hBEEF;
      repeat (45) @(negedge CLK);
      LOAD = 1'b0;
      repeat (5) @(negedge CLK);
      exp_frame[7] = 16'h1234;
      check_frame("long");

      wait_phase(9 * SD + 5, found);
      check("midrst_sync", 32'(found), 32'd1);
      RESET = 1'b0;
      #1;
      check_reset_vals("midrst");
      @(negedge CLK);
      check_reset_vals("midrst_hold");
      RESET = 1'b1;
      exp_frame = '{default: '0};
      exp_bank = 1'b0;
      for (int k = 0; k < 3 * SD; k++) begin
         check_timing("rst_scan");
         @(negedge CLK);
      end
      check_frame("rst_frame");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dot_matrix_driver.md
Name: dot_matrix_driver

Overview:
- Frame buffer and scan controller for a 16x16 LED dot-matrix display.
- Upstream logic writes 16-bit column words into a 32-column buffer (two 16-column banks) using a LOAD strobe.
- The block continuously scans the active bank and drives the column select, row data, column clock and blanking outputs to the display hardware.

Parameters:
- SCAN_DIV, 1024: CLK cycles per column slot; must be ≥ 8 and even.
- BLANK_CYCLES, 4: cycles at the start of each slot during which OUT_CLR is asserted; must be < SCAN_DIV/2.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- column_id  in  5  buffer column to write; bit4 selects the bank, bits3:0 select the column.
- in_column  in  16  column data; bit15 = top row.
- LOAD  in  1  write strobe; may be asynchronous to CLK.
- IN_CLR  in  1  synchronous buffer clear, active-high.
- column_seg  out  4  index of the currently driven column.
- out_column  out  16  row data for the driven column.
- COLUMN_CLK  out  1  column strobe to the display.
- OUT_CLR  out  1  blanking, active-high (display dark while 1).

Behaviour:
- Reset (RESET=0, asynchronous):
  - buffer all zero; bank=0; scan index=0; slot counter=0.
  - column_seg=0, out_column=0, COLUMN_CLK=0, OUT_CLR=1; synchronizer flops=0.
  - Reset asserted mid-scan or mid-write aborts everything; the first slot after release starts at column 0.
- LOAD path:
  - LOAD passes through a 2-flop synchronizer plus an edge register.
  - A rising edge writes in_column into buf[column_id] on the 3rd CLK edge after LOAD rises.
  - column_id and in_column are sampled at that write edge; the caller holds them stable for ≥4 cycles.
  - Each write sets bank <= column_id[4].
  - A level-high LOAD causes exactly one write.
- IN_CLR=1:
  - Clears all 32 buffer columns on that cycle; bank is unchanged.
  - IN_CLR has priority over a write occurring in the same cycle.
- Scan timing:
  - Slot counter cnt runs 0..SCAN_DIV-1 and wraps.
  - At cnt==SCAN_DIV-1 the scan index increments, wrapping 15->0.
  - At the same edge column_seg <= next index and out_column <= buf[{bank, next index}].
  - out_column changes only at slot boundaries; a write to the column currently displayed appears at its next scan.
  - A bank change takes effect at the next slot boundary.
- OUT_CLR = 1 while cnt < BLANK_CYCLES, else 0 (registered).
- COLUMN_CLK = 1 while BLANK_CYCLES ≤ cnt < SCAN_DIV/2, else 0 (registered).
- Full frame period = 16*SCAN_DIV cycles.
- After reset release, the first slot displays column 0 of bank 0 beginning at cnt=0.

Optional Feature:
- Macro DOT_MATRIX_ACTIVE_LOW_ROWS_EN.
- Defined: out_column is driven as the bitwise inverse of the buffer word; its reset value becomes 16'hFFFF.
- Undefined: out_column drives the buffer word directly (1 = LED on); reset value is 0.

Decomposition:
- Package dot_matrix_pkg holds:
  - constants NUM_ROWS=16, NUM_COLS=16, NUM_BANKS=2, COL_ID_W=5, SEL_W=4
  - a typedef for the 16-bit column word.
- One natural sub-module: load_edge_sync (2-flop synchronizer + rising-edge pulse, async active-low reset).
- The buffer, scan counter and output registers stay in the top module.

Test Plan:
- Reset: hold RESET=0 → column_seg=0, out_column=0, OUT_CLR=1, COLUMN_CLK=0. Release, SCAN_DIV=8, BLANK_CYCLES=2 → OUT_CLR=1 for cnt 0-1; COLUMN_CLK=1 for cnt 2-3; column_seg steps 0,1,..,15,0 every 8 cycles.
- Write/display: LOAD pulse with column_id=5'd3, in_column=16'hA5C3 → buffer written 3 cycles later; during slot 3, out_column=16'hA5C3; all other slots read 0.
- Bank switch: write column_id=5'd19 with 16'h00FF → bank=1; next frame shows 16'h00FF at column_seg=3 and no longer 16'hA5C3. Write column_id=3 → bank returns to 0.
- Clear priority: IN_CLR=1 in the same cycle as a write of 16'hFFFF to column 0 → all columns read 0 in the following frame.
- Long LOAD: LOAD held high for 50 cycles while in_column changes after cycle 5 → exactly one write, holding the value present at the write edge.
- Reset mid-slot: assert RESET at cnt=5 of column 9 → outputs return to reset values immediately; buffer is cleared; scan restarts at column 0.
